// File: rtl/console_pkg.sv
// Shared types and constants for the text console write-side controller
// and its address generator.
package console_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        ROWCLR
    } state_e;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    localparam int DEF_H = 80;
    localparam int DEF_V = 60;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_MIN) && (b <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/console_addr_gen.sv
// Maps (top_row, logical row, col) to a physical screen BRAM address,
// wrapping the row modulo V. Shared with the read-side pixel pipeline.
module console_addr_gen #(
    parameter int HORIZONTAL_SLOT_COUNT = 80,
    parameter int VERTICAL_SLOT_COUNT   = 60,
    parameter int SCREEN_ADDRESS_WIDTH  = 13,
    parameter int COL_WIDTH             = 7,
    parameter int ROW_WIDTH             = 6
) (
    input  logic [ROW_WIDTH-1:0]            top_row,
    input  logic [ROW_WIDTH-1:0]            row,
    input  logic [COL_WIDTH-1:0]            col,
    output logic [SCREEN_ADDRESS_WIDTH-1:0] addr
);

    logic [ROW_WIDTH:0]   row_sum;
    logic [ROW_WIDTH-1:0] phys_row;

    // NOTE: every variable in this block is assigned on all paths, so no latch is inferred.
    always_comb begin
        row_sum  = {1'b0, top_row} + {1'b0, row};
        phys_row = row_sum[ROW_WIDTH-1:0];
        if (row_sum >= (ROW_WIDTH+1)'(VERTICAL_SLOT_COUNT))
            phys_row = ROW_WIDTH'(row_sum - (ROW_WIDTH+1)'(VERTICAL_SLOT_COUNT));
        addr = SCREEN_ADDRESS_WIDTH'(phys_row) * SCREEN_ADDRESS_WIDTH'(HORIZONTAL_SLOT_COUNT)
             + SCREEN_ADDRESS_WIDTH'(col);
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Write-side controller for the text-mode screen BRAM: cursor, control codes,
// full/row clears. Define TEXT_SCROLL_EN to scroll via top_row instead of wrapping.
module text_console_ctrl
    import console_pkg::*;
#(
    parameter int          HORIZONTAL_SLOT_COUNT = DEF_H,
    parameter int          VERTICAL_SLOT_COUNT   = DEF_V,
    parameter int          SCREEN_ADDRESS_WIDTH  = 13,
    parameter int          COL_WIDTH             = 7,
    parameter int          ROW_WIDTH             = 6,
    parameter logic [6:0]  BLANK_CHAR            = 7'h20
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            ch_valid,
    input  logic [7:0]                      ch_data,
    output logic                            ch_ready,
    output logic                            wr_en,
    output logic [SCREEN_ADDRESS_WIDTH-1:0] wr_addr,
    output logic [6:0]                      wr_data,
    output logic [ROW_WIDTH-1:0]            top_row,
    output logic [COL_WIDTH-1:0]            cursor_col,
    output logic [ROW_WIDTH-1:0]            cursor_row,
    output logic                            busy
);

    localparam int H = HORIZONTAL_SLOT_COUNT;
    localparam int V = VERTICAL_SLOT_COUNT;

    state_e                          state;
    logic [SCREEN_ADDRESS_WIDTH-1:0] clr_cnt;
    logic [ROW_WIDTH-1:0]            clr_row;

    logic [ROW_WIDTH-1:0]            ag_top;
    logic [ROW_WIDTH-1:0]            ag_row;
    logic [COL_WIDTH-1:0]            ag_col;
    logic [SCREEN_ADDRESS_WIDTH-1:0] ag_addr;

    logic accept;
    logic printable;
    logic last_col;
    logic last_row;
    logic do_newline;

    console_addr_gen #(
        .HORIZONTAL_SLOT_COUNT (H),
        .VERTICAL_SLOT_COUNT   (V),
        .SCREEN_ADDRESS_WIDTH  (SCREEN_ADDRESS_WIDTH),
        .COL_WIDTH             (COL_WIDTH),
        .ROW_WIDTH             (ROW_WIDTH)
    ) u_addr_gen (
        .top_row (ag_top),
        .row     (ag_row),
        .col     (ag_col),
        .addr    (ag_addr)
    );

    // One address generator serves both the cursor path and the row-clear sweep.
    always_comb begin
        ag_top = top_row;
        ag_row = cursor_row;
        ag_col = cursor_col;
        if (state == ROWCLR) begin
            ag_top = clr_row;
            ag_row = '0;
            ag_col = clr_cnt[COL_WIDTH-1:0];
        end else if (ch_data == CC_BS) begin
            ag_col = cursor_col - 1'b1;
        end
    end

    always_comb begin
        accept     = ch_valid && ch_ready;
        printable  = is_printable(ch_data);
        last_col   = (cursor_col == COL_WIDTH'(H - 1));
        last_row   = (cursor_row == ROW_WIDTH'(V - 1));
        do_newline = accept && ((printable && last_col) || (ch_data == CC_LF));
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the block override the defaults.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clr_row    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= BLANK_CHAR;
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
            ch_ready   <= 1'b0;
            busy       <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            case (state)
                CLEAR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= clr_cnt;
                    wr_data <= BLANK_CHAR;
                    if (clr_cnt == SCREEN_ADDRESS_WIDTH'(H * V - 1)) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        ch_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ROWCLR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= ag_addr;
                    wr_data <= BLANK_CHAR;
                    if (clr_cnt == SCREEN_ADDRESS_WIDTH'(H - 1)) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        ch_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= ag_addr;
                            wr_data    <= ch_data[6:0];
                            cursor_col <= last_col ? '0 : cursor_col + 1'b1;
                        end else begin
                            case (ch_data)
                                CC_CR: cursor_col <= '0;
                                CC_BS: begin
                                    if (cursor_col != '0) begin
                                        cursor_col <= cursor_col - 1'b1;
                                        wr_en      <= 1'b1;
                                        wr_addr    <= ag_addr;
                                        wr_data    <= BLANK_CHAR;
                                    end
                                end
                                CC_FF: begin
                                    cursor_col <= '0;
                                    cursor_row <= '0;
                                    top_row    <= '0;
                                    clr_cnt    <= '0;
                                    state      <= CLEAR;
                                    ch_ready   <= 1'b0;
                                    busy       <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    if (do_newline) begin
                        if (!last_row) begin
                            cursor_row <= cursor_row + 1'b1;
                        end else begin
`ifdef TEXT_SCROLL_EN
                            // The old top row becomes the bottom line after the scroll.
                            top_row <= (top_row == ROW_WIDTH'(V - 1)) ? '0 : top_row + 1'b1;
                            clr_row <= top_row;
`else
                            cursor_row <= '0;
                            clr_row    <= '0;
`endif
                            clr_cnt  <= '0;
                            state    <= ROWCLR;
                            ch_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl (both TEXT_SCROLL_EN builds).
module tb_text_console_ctrl;

    localparam int H = 80;
    localparam int V = 60;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ch_valid = 1'b0;
    logic [7:0]  ch_data = 8'h00;
    logic        ch_ready;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [6:0]  wr_data;
    logic [5:0]  top_row;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_console_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .top_row    (top_row),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        ch_valid = 1'b1;
        ch_data  = b;
        step();
    endtask

    task automatic expect_wr(input string tag, input int addr, input logic [6:0] data);
        chk({tag, "_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_addr"}, 32'(wr_addr), 32'(addr));
        chk({tag, "_data"}, 32'(wr_data), 32'(data));
    endtask

    task automatic expect_rowclr(input string tag, input int base);
        int bad = 0;
        for (int i = 0; i < H; i++) begin
            step();
            if (!(wr_en === 1'b1 && wr_addr === 13'(base + i) && wr_data === 7'h20)) bad++;
            if (i < H - 1 && ch_ready !== 1'b0) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        step();
        while (wr_en !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk(tag, 32'(wr_en), 32'd1);
    endtask

    initial begin
        int bad;

        // Reset state
        resetn = 1'b0;
        step();
        step();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", 32'(wr_data), 32'h20);
        chk("rst_ready", 32'(ch_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cursor", {cursor_row, cursor_col}, 32'd0);
        chk("rst_top", 32'(top_row), 32'd0);

        // Power-on clear: exactly H*V consecutive blank writes
        resetn = 1'b1;
        wait_wr("clr_start");
        bad = 0;
        for (int i = 0; i < H * V; i++) begin
            if (!(wr_en === 1'b1 && wr_addr === 13'(i) && wr_data === 7'h20)) bad++;
            step();
        end
        chk("clr_seq", 32'(bad), 32'd0);
        chk("clr_end_wr_en", 32'(wr_en), 32'd0);
        chk("clr_end_ready", 32'(ch_ready), 32'd1);
        chk("clr_end_busy", 32'(busy), 32'd0);

        // Back-to-back printables
        put(8'h41);
        expect_wr("wr_A", 0, 7'h41);
        put(8'h42);
        expect_wr("wr_B", 1, 7'h42);
        chk("ab_col", 32'(cursor_col), 32'd2);
        ch_valid = 1'b0;
        step();
        chk("idle_no_wr", 32'(wr_en), 32'd0);

        // CR returns to column 0 without writing
        put(8'h0D);
        chk("cr_no_wr", 32'(wr_en), 32'd0);
        chk("cr_col", 32'(cursor_col), 32'd0);

        // Column wrap on row 0: plain newline, no clear
        bad = 0;
        for (int i = 0; i < H; i++) begin
            put(8'(8'h61 + i % 26));
            if (!(wr_en === 1'b1 && wr_addr === 13'(i) && wr_data === 7'(8'h61 + i % 26))) bad++;
        end
        ch_valid = 1'b0;
        chk("wrap_writes", 32'(bad), 32'd0);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd1);
        chk("wrap_ready", 32'(ch_ready), 32'd1);
        step();
        chk("wrap_no_clear", 32'(wr_en), 32'd0);
        chk("wrap_busy", 32'(busy), 32'd0);

        // Backspace and dropped codes on row 1
        put(8'h58);
        expect_wr("wr_X", 80, 7'h58);
        put(8'h08);
        expect_wr("bs1", 80, 7'h20);
        chk("bs1_col", 32'(cursor_col), 32'd0);
        put(8'h08);
        chk("bs0_no_wr", 32'(wr_en), 32'd0);
        chk("bs0_col", 32'(cursor_col), 32'd0);
        put(8'h7E);
        expect_wr("wr_7e", 80, 7'h7E);
        put(8'h0D);
        chk("cr2_no_wr", 32'(wr_en), 32'd0);
        chk("cr2_col", 32'(cursor_col), 32'd0);
        put(8'h85);
        chk("drop85_no_wr", 32'(wr_en), 32'd0);
        chk("drop85_ready", 32'(ch_ready), 32'd1);
        put(8'h7F);
        chk("drop7f_no_wr", 32'(wr_en), 32'd0);
        put(8'h1F);
        chk("drop1f_no_wr", 32'(wr_en), 32'd0);
        chk("drop_col", 32'(cursor_col), 32'd0);

        // Line feeds down to the last row
        for (int i = 0; i < V - 2; i++) put(8'h0A);
        ch_valid = 1'b0;
        chk("lf_row", 32'(cursor_row), 32'd59);
        chk("lf_col", 32'(cursor_col), 32'd0);
        chk("lf_no_wr", 32'(wr_en), 32'd0);

        // Wrap on the last row: character write first, then row clear
        bad = 0;
        for (int i = 0; i < H; i++) begin
            put(8'(8'h30 + i % 10));
            if (!(wr_en === 1'b1 && wr_addr === 13'(4720 + i) && wr_data === 7'(8'h30 + i % 10))) bad++;
        end
        ch_valid = 1'b0;
        chk("last_row_writes", 32'(bad), 32'd0);
        chk("last_row_busy", 32'(busy), 32'd1);
        chk("last_row_ready", 32'(ch_ready), 32'd0);
        expect_rowclr("last_row_clr", 0);
        chk("last_row_col", 32'(cursor_col), 32'd0);
`ifdef TEXT_SCROLL_EN
        chk("last_row_row", 32'(cursor_row), 32'd59);
        chk("last_row_top", 32'(top_row), 32'd1);
`else
        chk("last_row_row", 32'(cursor_row), 32'd0);
        chk("last_row_top", 32'(top_row), 32'd0);
`endif
        step();
        chk("rowclr_done", 32'(wr_en), 32'd0);
        put(8'h5A);
        expect_wr("wr_Z", 0, 7'h5A);
        put(8'h0D);

        // LF on the last row (scroll) or on row 0 (wrap build); 'Y' held while not ready
`ifdef TEXT_SCROLL_EN
        put(8'h0A);
        ch_data = 8'h59;
        chk("scroll_top", 32'(top_row), 32'd2);
        chk("scroll_row", 32'(cursor_row), 32'd59);
        chk("scroll_busy", 32'(busy), 32'd1);
        chk("scroll_ready", 32'(ch_ready), 32'd0);
        expect_rowclr("scroll_clr", 80);
        step();
        expect_wr("wr_Y", 80, 7'h59);
`else
        put(8'h0A);
        chk("lf_wrap_no_wr", 32'(wr_en), 32'd0);
        chk("lf_wrap_row", 32'(cursor_row), 32'd1);
        chk("lf_wrap_busy", 32'(busy), 32'd0);
        put(8'h59);
        expect_wr("wr_Y", 80, 7'h59);
`endif
        ch_valid = 1'b0;

        // Form feed, then reset in the middle of the clear
        put(8'h0C);
        ch_valid = 1'b0;
        chk("ff_no_wr", 32'(wr_en), 32'd0);
        chk("ff_busy", 32'(busy), 32'd1);
        chk("ff_ready", 32'(ch_ready), 32'd0);
        chk("ff_top", 32'(top_row), 32'd0);
        chk("ff_cursor", {cursor_row, cursor_col}, 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!(wr_en === 1'b1 && wr_addr === 13'(i) && wr_data === 7'h20)) bad++;
        end
        chk("ff_clr_seq", 32'(bad), 32'd0);
        resetn = 1'b0;
        step();
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        step();
        resetn = 1'b1;
        wait_wr("restart");
        chk("restart_addr", 32'(wr_addr), 32'd0);
        chk("restart_top", 32'(top_row), 32'd0);
        step();
        chk("restart_addr1", 32'(wr_addr), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
